// File: rtl/aca_pkg.sv
// Shared types and helpers for the variable-latency almost-correct adder.
// Supports operand widths up to ACA_MAX_W bits.
package aca_pkg;

  typedef enum logic {
    RUN = 1'b0,
    FIX = 1'b1
  } aca_state_e;

  localparam int ACA_WIDTH  = 16;
  localparam int ACA_WINDOW = 8;
  localparam int ACA_MAX_W  = 64;

  // True when p holds WINDOW consecutive ones starting at bit 1 or above.
  // p is zero-extended, so runs cannot extend past the real operand width.
  function automatic logic aca_run_flag(input logic [ACA_MAX_W-1:0] p,
                                        input int window);
    logic [ACA_MAX_W-1:0] run;
    run = p;
    for (int j = 1; j < ACA_MAX_W; j++) begin
      if (j < window) run = run & (p >> j);
    end
    return |run[ACA_MAX_W-1:1];
  endfunction

endpackage

// File: rtl/aca_spec_core.sv
// Windowed-carry speculative sum and speculation-hazard flag.
// Purely combinational.
module aca_spec_core
  import aca_pkg::*;
#(
  parameter int WIDTH  = ACA_WIDTH,
  parameter int WINDOW = ACA_WINDOW
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   spec_sum,
  output logic             flag
);

  logic [WIDTH-1:0] p;
  logic [WIDTH:1]   cspec;

  assign p = a ^ b;

  // Each carry is the carry-out of a short add over the look-back window;
  // a wrapped window sum smaller than an addend means it overflowed.
  for (genvar i = 1; i <= WIDTH; i++) begin : g_carry
    localparam int LO = (i > WINDOW) ? i - WINDOW : 0;
    localparam int N  = i - LO;
    logic [N-1:0] wa, wb, ws;
    assign wa       = a[i-1:LO];
    assign wb       = b[i-1:LO];
    assign ws       = wa + wb;
    assign cspec[i] = (ws < wa);
  end

  assign spec_sum[0] = p[0];
  for (genvar i = 1; i < WIDTH; i++) begin : g_sum
    assign spec_sum[i] = p[i] ^ cspec[i];
  end
  assign spec_sum[WIDTH] = cspec[WIDTH];

  assign flag = aca_run_flag(ACA_MAX_W'(p), WINDOW);

endmodule

// File: rtl/aca_vlsa_adder.sv
// Variable-latency speculative adder: returns the windowed-carry sum in two
// cycles, or spends one extra cycle on the exact sum for flagged exact beats.
module aca_vlsa_adder
  import aca_pkg::*;
#(
  parameter int WIDTH  = ACA_WIDTH,
  parameter int WINDOW = ACA_WINDOW,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             approx_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o,
  output logic             err_o,
  output logic [CNT_W-1:0] fix_cnt_o
);

  aca_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             mode_q, v1_q;
  logic [WIDTH:0]   spec_sum, exact_sum, s2_result;
  logic             flag, need_fix, s2_free, s2_load, s2_err, accept;

  aca_spec_core #(
    .WIDTH (WIDTH),
    .WINDOW(WINDOW)
  ) u_spec (
    .a       (a_q),
    .b       (b_q),
    .spec_sum(spec_sum),
    .flag    (flag)
  );

  // Multicycle path: S1 operands are held for the RUN->FIX cycle and FIX.
  assign exact_sum = {1'b0, a_q} + {1'b0, b_q};
  assign s2_free   = !out_valid_o || out_ready_i;
  assign need_fix  = v1_q && flag && !mode_q;
  assign accept    = in_valid_i && in_ready_o;

  always_comb begin
    state_d    = state_q;
    s2_load    = 1'b0;
    s2_result  = '0;
    s2_err     = 1'b0;
    in_ready_o = !v1_q;
    case (state_q)
      RUN: begin
        if (need_fix) begin
          state_d = FIX;
        end else if (v1_q && s2_free) begin
          s2_load    = 1'b1;
          s2_result  = spec_sum;
          s2_err     = flag;
          in_ready_o = 1'b1;
        end
      end
      FIX: begin
        if (s2_free) begin
          s2_load   = 1'b1;
          s2_result = exact_sum;
          s2_err    = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      v1_q   <= 1'b0;
    end else if (accept) begin
      a_q    <= add1_i;
      b_q    <= add2_i;
      mode_q <= approx_i;
      v1_q   <= 1'b1;
    end else if (s2_load) begin
      v1_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      result_o    <= '0;
      err_o       <= 1'b0;
    end else if (s2_load) begin
      out_valid_o <= 1'b1;
      result_o    <= s2_result;
      err_o       <= s2_err;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fix_cnt_o <= '0;
    end else if (s2_load && s2_err && (fix_cnt_o != '1)) begin
      fix_cnt_o <= fix_cnt_o + CNT_W'(1);
    end
  end

endmodule
